// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, oversampling constants and a
// 2-of-3 majority helper used when RX_MAJORITY_EN is defined.
package uart_pkg;

  localparam int unsigned OVS_TICKS = 16;
  localparam int unsigned MID_TICK  = 7;
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/receiver_sync_chain.sv
// Multi-flop synchronizer for an asynchronous level; flops reset to 1 so an
// idle serial line never looks like a start edge coming out of reset.
module sync_chain #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/receiver.sv
// UART 8N1 receiver on a 16x br_tick strobe. Define RX_MAJORITY_EN to take
// each bit as the 2-of-3 majority of three consecutive tick samples.
module receiver
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       br_tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       rx_busy,
  output logic       rx_frame_err
);

  // Majority mode delays the start decision by two ticks; the data/stop grid
  // shifts with it because tick_cnt is cleared at that decision.
`ifdef RX_MAJORITY_EN
  localparam logic [3:0] START_DECIDE = 4'(MID_TICK + 2);
`else
  localparam logic [3:0] START_DECIDE = 4'(MID_TICK);
`endif
  localparam logic [3:0] BIT_DECIDE = 4'(OVS_TICKS - 1);
  localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);

  logic       rx_s;
  logic       rx_s_d_q, rx_s_d_d;
  logic       sample;
  rx_state_e  state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_done_q, rx_done_d;
  logic       rx_busy_q, rx_busy_d;
  logic       rx_frame_err_q, rx_frame_err_d;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = br_tick ? {hist_q[0], rx_s} : hist_q;
    sample = majority3(hist_q[1], hist_q[0], rx_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '1;
    end else begin
      hist_q <= hist_d;
    end
  end
`else
  always_comb begin
    sample = rx_s;
  end
`endif

  always_comb begin
    rx_s_d_d       = rx_s;
    state_d        = state_q;
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_done_d      = 1'b0;
    rx_frame_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s_d_q && !rx_s) begin
          state_d    = START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
        end
      end
      START: begin
        if (br_tick) begin
          if (tick_cnt_q == START_DECIDE) begin
            tick_cnt_d = '0;
            state_d    = sample ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (br_tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == BIT_DECIDE) begin
            shift_d = {sample, shift_q[7:1]};
            if (bit_cnt_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
      end
      STOP: begin
        if (br_tick) begin
          if (tick_cnt_q == BIT_DECIDE) begin
            state_d = IDLE;
            if (sample) begin
              rx_data_d = shift_q;
              rx_done_d = 1'b1;
            end else begin
              rx_frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    rx_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s_d_q       <= 1'b1;
      state_q        <= IDLE;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_done_q      <= 1'b0;
      rx_busy_q      <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_s_d_q       <= rx_s_d_d;
      state_q        <= state_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_done_q      <= rx_done_d;
      rx_busy_q      <= rx_busy_d;
      rx_frame_err_q <= rx_frame_err_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_done      = rx_done_q;
  assign rx_busy      = rx_busy_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_receiver.sv
// Testbench for receiver: drives 8N1 frames at 64 clk/bit with br_tick every
// 4 clk and checks events against a queue of expected frame outcomes.
module tb_receiver;

  localparam int BIT_CLK = 64;
`ifdef RX_MAJORITY_EN
  localparam int FRAME_TICKS = 154;
`else
  localparam int FRAME_TICKS = 152;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       br_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rx_busy;
  logic       rx_frame_err;

  int unsigned total = 0;
  int unsigned bad = 0;

  // Reference model: each sent frame queues {is_error, byte}; model_data is the
  // last correctly framed byte.
  logic [8:0] exp_q[$];
  logic [7:0] model_data = 8'h00;
  int unsigned done_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned busy_ticks = 0;
  bit          saw_busy = 1'b0;
  bit          busy_prev = 1'b0;
  int unsigned div = 0;

  receiver #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .br_tick      (br_tick),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .rx_busy      (rx_busy),
    .rx_frame_err (rx_frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div = (div + 1) % 4;
    br_tick = (div == 0);
  end

  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      if (br_tick && busy_prev) busy_ticks++;
      busy_prev = rx_busy;
      if (rx_busy) saw_busy = 1'b1;
      if (rx_done && rx_frame_err) begin
        total++; bad++;
        $display("FAIL done_err_overlap: both pulses high at %0t, required at most one", $time);
      end
      if (rx_done) begin
        total++; done_cnt++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done: got data=%h, required no pulse", rx_data);
        end else begin
          e = exp_q.pop_front();
          if ({1'b0, rx_data} !== e) begin
            bad++;
            $display("FAIL done_data: got done with %h, required event err=%b data=%h", rx_data, e[8], e[7:0]);
          end
          if (!e[8]) model_data = e[7:0];
        end
      end
      if (rx_frame_err) begin
        total++; err_cnt++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_frame_err: got pulse, required none");
        end else begin
          e = exp_q.pop_front();
          if (!e[8] || rx_data !== model_data) begin
            bad++;
            $display("FAIL frame_err_event: got err with rx_data=%h, required err=%b hold=%h", rx_data, e[8], model_data);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit spike);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    exp_q.push_back({~stop, b});
    for (int i = 0; i < 10; i++) begin
      if (spike && i < 9) begin
        drive(bits[i], 32);
        drive(~bits[i], 4);
        drive(bits[i], 28);
      end else begin
        drive(bits[i], BIT_CLK);
      end
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if (exp_q.size() != 0 || rx_busy !== 1'b0 || rx_data !== model_data) begin
      bad++;
      $display("FAIL %s: got pending=%0d busy=%b data=%h, required 0/0/%h",
               name, exp_q.size(), rx_busy, rx_data, model_data);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || rx_busy !== 1'b0 || rx_frame_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h done=%b busy=%b err=%b, required 00/0/0/0",
               rx_data, rx_done, rx_busy, rx_frame_err);
    end
    rst = 1'b0;
    drive(1'b1, 2 * BIT_CLK);
  endtask

  task automatic test_single;
    int unsigned d0;
    d0 = done_cnt;
    busy_ticks = 0;
    send_frame(8'hA5, 1'b1, 1'b0);
    drive(1'b1, 2 * BIT_CLK);
    total++;
    if (done_cnt - d0 != 1 || rx_data !== 8'hA5) begin
      bad++;
      $display("FAIL single_a5: got %0d pulses data=%h, required 1 pulse data=a5", done_cnt - d0, rx_data);
    end
    total++;
    if (busy_ticks != FRAME_TICKS) begin
      bad++;
      $display("FAIL busy_length: got %0d ticks, required %0d", busy_ticks, FRAME_TICKS);
    end
    check_idle("single_idle");
  endtask

  task automatic test_back_to_back;
    int unsigned d0;
    d0 = done_cnt;
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    drive(1'b1, 2 * BIT_CLK);
    total++;
    if (done_cnt - d0 != 2 || rx_data !== 8'hC3) begin
      bad++;
      $display("FAIL back_to_back: got %0d pulses data=%h, required 2 pulses data=c3", done_cnt - d0, rx_data);
    end
    check_idle("b2b_idle");
  endtask

  task automatic test_glitch;
    int unsigned d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    saw_busy = 1'b0;
    drive(1'b0, 8);
    drive(1'b1, 3 * BIT_CLK);
    total++;
    if (saw_busy !== 1'b1 || done_cnt != d0 || err_cnt != e0) begin
      bad++;
      $display("FAIL glitch: got busy_seen=%b pulses=%0d errs=%0d, required 1/0/0",
               saw_busy, done_cnt - d0, err_cnt - e0);
    end
    check_idle("glitch_idle");
  endtask

  task automatic test_frame_err;
    int unsigned e0, d0;
    e0 = err_cnt;
    d0 = done_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    busy_ticks = 0;
    saw_busy = 1'b0;
    drive(1'b0, 20 * BIT_CLK);
    total++;
    if (err_cnt - e0 != 1 || done_cnt != d0 || rx_data !== 8'hC3) begin
      bad++;
      $display("FAIL frame_err: got errs=%0d pulses=%0d data=%h, required 1/0/c3",
               err_cnt - e0, done_cnt - d0, rx_data);
    end
    total++;
    if (saw_busy !== 1'b0 || busy_ticks != 0) begin
      bad++;
      $display("FAIL held_low_retrigger: got busy_seen=%b, required 0", saw_busy);
    end
    drive(1'b1, 2 * BIT_CLK);
    check_idle("frame_err_idle");
  endtask

  task automatic test_reset_abort;
    int unsigned d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    drive(1'b0, BIT_CLK);
    drive(1'b1, 4 * BIT_CLK + 32);
    rst = 1'b1;
    model_data = 8'h00;
    drive(1'b1, 4);
    total++;
    if (rx_data !== 8'h00 || rx_done !== 1'b0 || rx_busy !== 1'b0 || rx_frame_err !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: got data=%h done=%b busy=%b err=%b, required 00/0/0/0",
               rx_data, rx_done, rx_busy, rx_frame_err);
    end
    rst = 1'b0;
    drive(1'b1, 28 + 4 * BIT_CLK);
    total++;
    if (done_cnt != d0 || err_cnt != e0) begin
      bad++;
      $display("FAIL abort_no_pulse: got pulses=%0d errs=%0d, required 0/0", done_cnt - d0, err_cnt - e0);
    end
    send_frame(8'h12, 1'b1, 1'b0);
    drive(1'b1, 2 * BIT_CLK);
    total++;
    if (done_cnt - d0 != 1 || rx_data !== 8'h12) begin
      bad++;
      $display("FAIL after_abort: got %0d pulses data=%h, required 1 pulse data=12", done_cnt - d0, rx_data);
    end
    check_idle("abort_idle");
  endtask

  task automatic test_random;
    logic [7:0] b;
    logic       stop;
    int unsigned gap;
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(3) != 0);
      gap = $urandom_range(2);
      if (!stop && gap == 0) gap = 1;
      send_frame(b, stop, 1'b0);
      drive(1'b1, int'(gap) * BIT_CLK);
    end
    drive(1'b1, 2 * BIT_CLK);
    check_idle("random_stream");
  endtask

`ifdef RX_MAJORITY_EN
  task automatic test_majority;
    int unsigned e0;
    e0 = err_cnt;
    send_frame(8'h81, 1'b1, 1'b1);
    drive(1'b1, 2 * BIT_CLK);
    total++;
    if (rx_data !== 8'h81 || err_cnt != e0) begin
      bad++;
      $display("FAIL majority_spike: got data=%h errs=%0d, required 81/0", rx_data, err_cnt - e0);
    end
    check_idle("majority_idle");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_abort();
    test_random();
`ifdef RX_MAJORITY_EN
    test_majority();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
